// File: rtl/logger_ev_gen.sv
// logger_ev_gen: staggered periodic multi-channel event source, round-robin merged onto one valid/ready stream.
// Define LOGGER_EV_GEN_LFSR_EN to add a 16-bit LFSR jitter term to each event delta.
module logger_ev_gen #(
    parameter int ID_W          = 16,
    parameter int TS_W          = 64,
    parameter int NUM_CH        = 4,
    parameter int PERIOD_CYCLES = 50_000_000,
    parameter int FIXED_DELTA   = 1000,
    parameter int DROP_W        = 32,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ID_W-1:0]   out_id,
    output logic [CH_W-1:0]   out_ch,
    output logic [TS_W-1:0]   out_start_ts,
    output logic [TS_W-1:0]   out_end_ts,
    output logic [TS_W-1:0]   out_delta,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int TMR_W = $clog2(PERIOD_CYCLES);

    logic [TS_W-1:0]   ts;
    logic [TMR_W-1:0]  timer [NUM_CH];
    logic [TS_W-1:0]   start_ts [NUM_CH];
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] fire;
    logic [NUM_CH-1:0] take;
    logic [NUM_CH-1:0] drop;
    logic [CH_W-1:0]   last_grant;
    logic [CH_W-1:0]   grant_ch;
    logic              found;
    logic              load_ok;
    logic              grant;
    logic [TS_W-1:0]   delta;
    logic [4:0]        drops_now;
    logic [DROP_W:0]   drop_sum;

    always_ff @(posedge clk) begin
        if (rst) ts <= '0;
        else     ts <= ts + TS_W'(1);
    end

    // Channel k starts k*(PERIOD/NUM_CH) clocks closer to its first fire.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (rst)
                timer[k] <= TMR_W'(PERIOD_CYCLES - 1 - k * (PERIOD_CYCLES / NUM_CH));
            else if (enable)
                timer[k] <= (timer[k] == '0) ? TMR_W'(PERIOD_CYCLES - 1) : timer[k] - TMR_W'(1);
        end
    end

    always_comb begin
        fire      = '0;
        found     = 1'b0;
        grant_ch  = '0;
        take      = '0;
        drop      = '0;
        drops_now = '0;
        for (int k = 0; k < NUM_CH; k++)
            fire[k] = enable && (timer[k] == '0);
        // Round-robin: first pending above last_grant, then wrap to the bottom.
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && pending[i] && (i > int'(last_grant))) begin
                found    = 1'b1;
                grant_ch = CH_W'(i);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && pending[i] && (i <= int'(last_grant))) begin
                found    = 1'b1;
                grant_ch = CH_W'(i);
            end
        end
        load_ok = !out_valid || out_ready;
        grant   = load_ok && found;
        for (int k = 0; k < NUM_CH; k++) begin
            take[k] = grant && (int'(grant_ch) == k);
            drop[k] = fire[k] && pending[k] && !take[k];
            if (drop[k]) drops_now = drops_now + 5'd1;
        end
        drop_sum = {1'b0, drop_cnt} + (DROP_W + 1)'(drops_now);
    end

`ifdef LOGGER_EV_GEN_LFSR_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst)        lfsr <= 16'hACE1;
        else if (grant) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end

    assign delta = TS_W'(FIXED_DELTA) + TS_W'(lfsr[7:0]);
`else
    assign delta = TS_W'(FIXED_DELTA);
`endif

    // A fire on a channel being granted this cycle re-arms it rather than dropping.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            for (int k = 0; k < NUM_CH; k++) start_ts[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (fire[k] && !drop[k]) begin
                    pending[k]  <= 1'b1;
                    start_ts[k] <= ts;
                end else if (take[k]) begin
                    pending[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                   drop_cnt <= '0;
        else if (drop_sum[DROP_W]) drop_cnt <= '1;
        else                       drop_cnt <= drop_sum[DROP_W-1:0];
    end

    // out_id doubles as the sequence counter: it always holds the last issued ID.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_id       <= '0;
            out_ch       <= '0;
            out_start_ts <= '0;
            out_end_ts   <= '0;
            out_delta    <= '0;
            last_grant   <= CH_W'(NUM_CH - 1);
        end else if (grant) begin
            out_valid    <= 1'b1;
            out_id       <= out_id + ID_W'(1);
            out_ch       <= grant_ch;
            out_start_ts <= start_ts[grant_ch];
            out_end_ts   <= start_ts[grant_ch] + delta;
            out_delta    <= delta;
            last_grant   <= grant_ch;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
